// File: rtl/io_ws.sv
// CPU bus address decoder with an internal control register, per-region wait
// states on n_rdy, configurable IO slots and a sticky bus-error flag.
module io_ws #(
    parameter int ROM_WS   = 1,
    parameter int RAM_WS   = 0,
    parameter int IO_WS    = 2,
    parameter int IO_SLOTS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] a,
    input  logic        n_oe,
    input  logic        n_we,
    input  logic [7:0]  d_in,
    output logic [7:0]  d_out,
    output logic        d_oe,
    output logic        n_rdy,
    output logic        n_rom_cs,
    output logic        n_raml_cs,
    output logic        n_ramh_cs,
    output logic [7:0]  n_io_oe,
    output logic [7:0]  io_cp,
    output logic [7:0]  cr
);

    localparam logic [3:0] ROM_W = 4'(ROM_WS);
    localparam logic [3:0] RAM_W = 4'(RAM_WS);
    localparam logic [3:0] IO_W  = 4'(IO_WS);
    localparam logic [3:0] SLOTS = 4'(IO_SLOTS);

    typedef enum logic [2:0] {
        REG_ROM,
        REG_RAM,
        REG_OFF,
        REG_EMPTY,
        REG_CR,
        REG_SLOT
    } region_t;

    region_t     region;
    logic [2:0]  slot;
    logic [2:0]  widx;
    logic [3:0]  ws;
    logic [15:0] a_q;
    logic        act_q;
    logic [3:0]  cnt;
    logic        wr_done;
    logic [7:0]  cr_q;
    logic        active;
    logic        new_acc;
    logic        rdy_wait;
    logic        cr_wr;
    logic        err_set;

    assign slot = a[3:1];
    // Windows A..E map onto cr[3..7]; a[14:12] + 1 yields exactly that index.
    assign widx = a[14:12] + 3'd1;

    // NOTE: every output of a combinational block gets a default first so no
    // path through the if-chain can leave a value unassigned (no latch).
    always_comb begin
        region    = REG_EMPTY;
        n_rom_cs  = 1'b1;
        n_raml_cs = 1'b1;
        n_ramh_cs = 1'b1;
        if (!a[15]) begin
            n_rom_cs  = cr_q[0];
            n_raml_cs = ~cr_q[0];
            region    = cr_q[0] ? REG_RAM : REG_ROM;
        end else if (a[15:13] == 3'b100) begin
            n_ramh_cs = 1'b0;
            region    = REG_RAM;
        end else if (a[15:12] != 4'hF) begin
            n_ramh_cs = ~cr_q[widx];
            region    = cr_q[widx] ? REG_RAM : REG_OFF;
        end else if (a[11:8] != 4'hF) begin
            region = REG_EMPTY;
        end else if (slot == 3'd1) begin
            region = REG_CR;
        end else if ({1'b0, slot} < SLOTS) begin
            region = REG_SLOT;
        end
    end

    always_comb begin
        case (region)
            REG_ROM:          ws = ROM_W;
            REG_RAM:          ws = RAM_W;
            REG_CR, REG_SLOT: ws = IO_W;
            default:          ws = 4'd0;
        endcase
    end

    assign active   = ~n_oe | ~n_we;
    assign new_acc  = active & (~act_q | (a != a_q));
    assign rdy_wait = new_acc ? (ws != 4'd0) : (active & (cnt != 4'd0));
    // Ready is forced low while reset is held, even with an access pending.
    assign n_rdy    = ~rst & rdy_wait;
    assign cr_wr    = ~n_we & (region == REG_CR) & ~rdy_wait & ~wr_done;
    assign err_set  = new_acc & (region == REG_EMPTY);

    assign d_oe  = ~rst & ~n_oe & (region == REG_CR);
    assign d_out = d_oe ? cr_q : 8'h00;
    assign cr    = cr_q;

    always_comb begin
        n_io_oe = 8'hFF;
        io_cp   = 8'hFF;
        if (region == REG_SLOT) begin
            n_io_oe[slot] = n_oe;
            io_cp[slot]   = ~(~n_we & ~n_rdy);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= 16'h0000;
            act_q   <= 1'b0;
            cnt     <= 4'd0;
            wr_done <= 1'b0;
            cr_q    <= 8'h00;
        end else begin
            a_q   <= a;
            act_q <= active;

            if (new_acc && ws != 4'd0)
                cnt <= ws - 4'd1;
            else if (cnt != 4'd0)
                cnt <= cnt - 4'd1;

            if (cr_wr)
                wr_done <= 1'b1;
            else if (!active || new_acc)
                wr_done <= 1'b0;

            if (cr_wr) begin
                cr_q[7:3] <= d_in[7:3];
                cr_q[2]   <= 1'b0;
                cr_q[0]   <= d_in[0];
            end

            // A new error wins over a same-edge write-1-to-clear.
            if (err_set)
                cr_q[1] <= 1'b1;
            else if (cr_wr && d_in[1])
                cr_q[1] <= 1'b0;
        end
    end

endmodule
